// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button-driven time-setting controller for the BCD clock counter
module time_set_ctrl #(
   parameter int TIMEOUT_S = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic       clk_1hz_tick,
   input  logic [7:0] cur_hh,
   input  logic [7:0] cur_mm,
   input  logic [7:0] cur_ss,
   output logic       set_en,
   output logic       set_load,
   output logic [7:0] set_hh,
   output logic [7:0] set_mm,
   output logic [7:0] set_ss,
   output logic [1:0] field_sel
);

   localparam int CNT_W = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_S);
   localparam logic TO_ENABLED = (TIMEOUT_S > 0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SET_HH = 3'd1,
      SET_MM = 3'd2,
      SET_SS = 3'd3,
      LOAD   = 3'd4
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [2:0]       b_q;
   logic             mode_p;
   logic             inc_p;
   logic             dec_p;
   logic             editing;
   logic             timeout;
   logic             edit_ok;
   logic [CNT_W-1:0] idle_cnt;
   logic [7:0]       hh_q;
   logic [7:0]       mm_q;
   logic [7:0]       ss_q;

   // BCD increment with wrap to 00 at (or beyond) the field maximum
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      if (v >= max)
         bcd_inc = 8'h00;
      else if (v[3:0] >= 4'd9)
         bcd_inc = {v[7:4] + 4'd1, 4'h0};
      else
         bcd_inc = v + 8'd1;
   endfunction

   // BCD decrement; zero or out-of-range values land on the field maximum
   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
      if ((v == 8'h00) || (v > max))
         bcd_dec = max;
      else if (v[3:0] == 4'd0)
         bcd_dec = {v[7:4] - 4'd1, 4'h9};
      else
         bcd_dec = v - 8'd1;
   endfunction

   assign mode_p  = btn_mode & ~b_q[2];
   assign inc_p   = btn_inc  & ~b_q[1];
   assign dec_p   = btn_dec  & ~b_q[0];
   assign editing = (state_q == SET_HH) || (state_q == SET_MM) || (state_q == SET_SS);
   assign timeout = TO_ENABLED && editing && (idle_cnt >= TO_VAL);
   // mode beats inc/dec, timeout suppresses edits, inc+dec together cancel
   assign edit_ok = editing && !mode_p && !timeout && (inc_p ^ dec_p);

   assign set_hh = hh_q;
   assign set_mm = mm_q;
   assign set_ss = ss_q;

   // Registered button copies for rising-edge press detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         b_q <= 3'b000;
      else
         b_q <= {btn_mode, btn_inc, btn_dec};
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic and state-decoded outputs
   always_comb begin
      state_d   = state_q;
      set_en    = 1'b0;
      set_load  = 1'b0;
      field_sel = 2'd0;
      case (state_q)
         IDLE: begin
            if (mode_p) state_d = SET_HH;
         end
         SET_HH: begin
            set_en    = 1'b1;
            field_sel = 2'd1;
            if (mode_p)       state_d = SET_MM;
            else if (timeout) state_d = IDLE;
         end
         SET_MM: begin
            set_en    = 1'b1;
            field_sel = 2'd2;
            if (mode_p)       state_d = SET_SS;
            else if (timeout) state_d = IDLE;
         end
         SET_SS: begin
            set_en    = 1'b1;
            field_sel = 2'd3;
            if (mode_p)       state_d = LOAD;
            else if (timeout) state_d = IDLE;
         end
         LOAD: begin
            set_en    = 1'b1;
            set_load  = 1'b1;
            field_sel = 2'd3;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Edit registers: capture running time on entry, then apply inc/dec to the selected field
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hh_q <= 8'h12;
         mm_q <= 8'h00;
         ss_q <= 8'h00;
      end else if ((state_q == IDLE) && mode_p) begin
         hh_q <= cur_hh;
         mm_q <= cur_mm;
         ss_q <= cur_ss;
      end else if (edit_ok) begin
         case (state_q)
            SET_HH:  hh_q <= inc_p ? bcd_inc(hh_q, 8'h23) : bcd_dec(hh_q, 8'h23);
            SET_MM:  mm_q <= inc_p ? bcd_inc(mm_q, 8'h59) : bcd_dec(mm_q, 8'h59);
            SET_SS:  ss_q <= inc_p ? bcd_inc(ss_q, 8'h59) : bcd_dec(ss_q, 8'h59);
            default: ;
         endcase
      end
   end

   // Inactivity counter: cleared on entry and on any press, saturating count of 1 Hz ticks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         idle_cnt <= '0;
      else if (!TO_ENABLED)
         idle_cnt <= '0;
      else if ((state_q == IDLE) && mode_p)
         idle_cnt <= '0;
      else if (editing) begin
         if (mode_p || inc_p || dec_p)
            idle_cnt <= '0;
         else if (clk_1hz_tick && (idle_cnt < TO_VAL))
            idle_cnt <= idle_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed scoreboard bench for time_set_ctrl
module tb_time_set_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_mode, btn_inc, btn_dec, clk_1hz_tick;
   logic [7:0] cur_hh, cur_mm, cur_ss;
   logic       set_en, set_load;
   logic [7:0] set_hh, set_mm, set_ss;
   logic [1:0] field_sel;

   int checks   = 0;
   int failures = 0;
   int load_cnt = 0;

   typedef struct {
      logic [1:0] fs;
      logic       en;
      logic       ld;
      logic [7:0] hh;
      logic [7:0] mm;
      logic [7:0] ss;
      string      tag;
   } exp_t;

   exp_t exp_q[$];

   time_set_ctrl #(.TIMEOUT_S(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_mode     (btn_mode),
      .btn_inc      (btn_inc),
      .btn_dec      (btn_dec),
      .clk_1hz_tick (clk_1hz_tick),
      .cur_hh       (cur_hh),
      .cur_mm       (cur_mm),
      .cur_ss       (cur_ss),
      .set_en       (set_en),
      .set_load     (set_load),
      .set_hh       (set_hh),
      .set_mm       (set_mm),
      .set_ss       (set_ss),
      .field_sel    (field_sel)
   );

   always #5 clk = ~clk;

   // count load strobes seen on the output, sampled away from the active edge
   always @(negedge clk) if (set_load === 1'b1) load_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input logic [1:0] fs, input logic en, input logic ld,
                           input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss,
                           input string tag);
      exp_t e;
      e.fs = fs; e.en = en; e.ld = ld; e.hh = hh; e.mm = mm; e.ss = ss; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      checks++;
      assert (exp_q.size() > 0) else begin
         failures++;
         $error("FAIL scoreboard_empty got=%0d exp=>0", exp_q.size());
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         assert (field_sel === e.fs) else begin
            failures++; $error("FAIL %s field_sel got=%0d exp=%0d", e.tag, field_sel, e.fs);
         end
         checks++;
         assert (set_en === e.en) else begin
            failures++; $error("FAIL %s set_en got=%b exp=%b", e.tag, set_en, e.en);
         end
         checks++;
         assert (set_load === e.ld) else begin
            failures++; $error("FAIL %s set_load got=%b exp=%b", e.tag, set_load, e.ld);
         end
         checks++;
         assert (set_hh === e.hh) else begin
            failures++; $error("FAIL %s set_hh got=%h exp=%h", e.tag, set_hh, e.hh);
         end
         checks++;
         assert (set_mm === e.mm) else begin
            failures++; $error("FAIL %s set_mm got=%h exp=%h", e.tag, set_mm, e.mm);
         end
         checks++;
         assert (set_ss === e.ss) else begin
            failures++; $error("FAIL %s set_ss got=%h exp=%h", e.tag, set_ss, e.ss);
         end
      end
   endtask

   // drive one cycle of inputs (called at a negedge), queue expectation, check after the edge
   task automatic step(input logic m, input logic i, input logic d, input logic t,
                       input logic [1:0] fs, input logic en, input logic ld,
                       input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss,
                       input string tag);
      btn_mode = m; btn_inc = i; btn_dec = d; clk_1hz_tick = t;
      push_exp(fs, en, ld, hh, mm, ss, tag);
      @(posedge clk);
      @(negedge clk);
      check_out();
   endtask

   task automatic check_loads(input int exp_n, input string tag);
      checks++;
      assert (load_cnt === exp_n) else begin
         failures++; $error("FAIL %s load_count got=%0d exp=%0d", tag, load_cnt, exp_n);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      btn_mode = 0; btn_inc = 0; btn_dec = 0; clk_1hz_tick = 0;
      cur_hh = 8'h08; cur_mm = 8'h30; cur_ss = 8'h15;
      @(negedge clk);
      @(negedge clk);
      push_exp(2'd0, 0, 0, 8'h12, 8'h00, 8'h00, "reset");
      check_out();
      rst_n = 1'b1;
      @(negedge clk);

      // capture and load with no edits
      step(1,0,0,0, 2'd1,1,0, 8'h08,8'h30,8'h15, "cap_hh");
      step(0,0,0,0, 2'd1,1,0, 8'h08,8'h30,8'h15, "cap_hh_rel");
      step(1,0,0,0, 2'd2,1,0, 8'h08,8'h30,8'h15, "cap_mm");
      step(0,0,0,0, 2'd2,1,0, 8'h08,8'h30,8'h15, "cap_mm_rel");
      step(1,0,0,0, 2'd3,1,0, 8'h08,8'h30,8'h15, "cap_ss");
      step(0,0,0,0, 2'd3,1,0, 8'h08,8'h30,8'h15, "cap_ss_rel");
      step(1,0,0,0, 2'd3,1,1, 8'h08,8'h30,8'h15, "cap_load");
      step(0,0,0,0, 2'd0,0,0, 8'h08,8'h30,8'h15, "cap_idle");
      check_loads(1, "cap");

      // BCD wrap cases
      cur_hh = 8'h23; cur_mm = 8'h09; cur_ss = 8'h59;
      step(1,0,0,0, 2'd1,1,0, 8'h23,8'h09,8'h59, "w_enter");
      step(0,0,0,0, 2'd1,1,0, 8'h23,8'h09,8'h59, "w_rel0");
      step(0,1,0,0, 2'd1,1,0, 8'h00,8'h09,8'h59, "hh_inc_wrap");
      step(0,0,0,0, 2'd1,1,0, 8'h00,8'h09,8'h59, "w_rel1");
      step(0,0,1,0, 2'd1,1,0, 8'h23,8'h09,8'h59, "hh_dec_wrap");
      step(0,0,0,0, 2'd1,1,0, 8'h23,8'h09,8'h59, "w_rel2");
      step(1,0,0,0, 2'd2,1,0, 8'h23,8'h09,8'h59, "w_to_mm");
      step(0,0,0,0, 2'd2,1,0, 8'h23,8'h09,8'h59, "w_rel3");
      step(0,1,0,0, 2'd2,1,0, 8'h23,8'h10,8'h59, "mm_inc_carry");
      step(0,0,0,0, 2'd2,1,0, 8'h23,8'h10,8'h59, "w_rel4");
      step(0,0,1,0, 2'd2,1,0, 8'h23,8'h09,8'h59, "mm_dec_borrow");
      step(0,0,0,0, 2'd2,1,0, 8'h23,8'h09,8'h59, "w_rel5");
      step(1,0,0,0, 2'd3,1,0, 8'h23,8'h09,8'h59, "w_to_ss");
      step(0,0,0,0, 2'd3,1,0, 8'h23,8'h09,8'h59, "w_rel6");
      step(0,1,0,0, 2'd3,1,0, 8'h23,8'h09,8'h00, "ss_inc_wrap");
      step(0,0,0,0, 2'd3,1,0, 8'h23,8'h09,8'h00, "w_rel7");
      step(1,0,0,0, 2'd3,1,1, 8'h23,8'h09,8'h00, "w_load");
      step(0,0,0,0, 2'd0,0,0, 8'h23,8'h09,8'h00, "w_idle");
      check_loads(2, "wrap");

      // invalid hours, held button, inc+dec together
      cur_hh = 8'h2A; cur_mm = 8'h41; cur_ss = 8'h00;
      step(1,0,0,0, 2'd1,1,0, 8'h2A,8'h41,8'h00, "inv_enter");
      step(0,0,0,0, 2'd1,1,0, 8'h2A,8'h41,8'h00, "inv_rel0");
      step(0,0,1,0, 2'd1,1,0, 8'h23,8'h41,8'h00, "hh_dec_invalid");
      step(0,0,0,0, 2'd1,1,0, 8'h23,8'h41,8'h00, "inv_rel1");
      step(1,0,0,0, 2'd2,1,0, 8'h23,8'h41,8'h00, "held_to_mm");
      step(0,0,0,0, 2'd2,1,0, 8'h23,8'h41,8'h00, "held_rel0");
      for (int k = 0; k < 20; k++)
         step(0,1,0,0, 2'd2,1,0, 8'h23,8'h42,8'h00, "held_inc");
      step(0,0,0,0, 2'd2,1,0, 8'h23,8'h42,8'h00, "held_rel1");
      step(0,1,1,0, 2'd2,1,0, 8'h23,8'h42,8'h00, "inc_dec_both");
      step(0,0,0,0, 2'd2,1,0, 8'h23,8'h42,8'h00, "both_rel");
      step(1,0,0,0, 2'd3,1,0, 8'h23,8'h42,8'h00, "inv_to_ss");
      step(0,0,0,0, 2'd3,1,0, 8'h23,8'h42,8'h00, "inv_rel2");
      step(1,0,0,0, 2'd3,1,1, 8'h23,8'h42,8'h00, "inv_load");
      step(0,0,0,0, 2'd0,0,0, 8'h23,8'h42,8'h00, "inv_idle");
      check_loads(3, "held");

      // mode and inc together in SET_HH, then reset in SET_MM
      cur_hh = 8'h05; cur_mm = 8'h06; cur_ss = 8'h07;
      step(1,0,0,0, 2'd1,1,0, 8'h05,8'h06,8'h07, "mi_enter");
      step(0,0,0,0, 2'd1,1,0, 8'h05,8'h06,8'h07, "mi_rel0");
      step(1,1,0,0, 2'd2,1,0, 8'h05,8'h06,8'h07, "mode_inc_same");
      step(0,0,0,0, 2'd2,1,0, 8'h05,8'h06,8'h07, "mi_rel1");
      rst_n = 1'b0;
      #1;
      push_exp(2'd0, 0, 0, 8'h12, 8'h00, 8'h00, "async_reset");
      check_out();
      @(negedge clk);
      rst_n = 1'b1;
      step(0,0,0,0, 2'd0,0,0, 8'h12,8'h00,8'h00, "post_reset");
      step(0,0,0,0, 2'd0,0,0, 8'h12,8'h00,8'h00, "post_reset2");
      check_loads(3, "reset");

      // timeout with a restart after two ticks
      step(1,0,0,0, 2'd1,1,0, 8'h05,8'h06,8'h07, "to_enter");
      step(0,0,0,0, 2'd1,1,0, 8'h05,8'h06,8'h07, "to_rel0");
      step(0,0,0,1, 2'd1,1,0, 8'h05,8'h06,8'h07, "to_tick1");
      step(0,0,0,1, 2'd1,1,0, 8'h05,8'h06,8'h07, "to_tick2");
      step(0,1,0,0, 2'd1,1,0, 8'h06,8'h06,8'h07, "to_press");
      step(0,0,0,0, 2'd1,1,0, 8'h06,8'h06,8'h07, "to_rel1");
      step(0,0,0,1, 2'd1,1,0, 8'h06,8'h06,8'h07, "to_restart1");
      step(0,0,0,0, 2'd1,1,0, 8'h06,8'h06,8'h07, "to_restart_hold");
      step(0,0,0,1, 2'd1,1,0, 8'h06,8'h06,8'h07, "to_restart2");
      step(0,0,0,1, 2'd1,1,0, 8'h06,8'h06,8'h07, "to_restart3");
      step(0,0,0,0, 2'd0,0,0, 8'h06,8'h06,8'h07, "to_expired");
      step(0,0,0,0, 2'd0,0,0, 8'h06,8'h06,8'h07, "to_idle");
      check_loads(3, "timeout");

      checks++;
      assert (exp_q.size() == 0) else begin
         failures++; $error("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
